add_scheduler: RTL and testbench
================================

ADD_SCHEDULER -- requirements
Module: add_scheduler

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: operand width in 4-bit nibbles, legal range 1..8.
REQ-002 SHALL define W = 4*NIBBLES as the operand/result width used below.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req0_valid  in  1  requester 0 has an operation pending.
REQ-007 req0_ready  out  1  requester 0 operands accepted this cycle.
REQ-008 req0_a, req0_b  in  W each  requester 0 operands.
REQ-009 req0_ci  in  1  requester 0 carry-in.
REQ-010 req1_valid, req1_ready, req1_a, req1_b, req1_ci  SHALL mirror REQ-006..009 for requester 1.
REQ-011 res_valid  out  1  result available.
REQ-012 res_ready  in  1  consumer accepts result.
REQ-013 res_sum  out  W  registered sum.
REQ-014 res_carry  out  1  registered carry-out of the MSB nibble.
REQ-015 res_id  out  1  index of the requester that owns the result.

Function
REQ-016 SHALL instantiate exactly one existing 4-bit ripple adder block and time-share it for all additions; no other adder logic.
REQ-017 Transfer on any port SHALL occur only on a rising edge with valid=1 and ready=1.
REQ-018 FSM states SHALL be IDLE, ADD, HOLD.
REQ-019 IDLE: req_ready SHALL be asserted combinationally only to the granted requester, and only while that requester's valid=1; the other ready SHALL be 0.
REQ-020 Grant: one requester valid -> grant it; both valid -> grant the one not granted last (round-robin); after reset requester 0 has priority.
REQ-021 On acceptance: latch a, b, ci, and id; clear nibble counter; go to ADD; update last-grant.
REQ-022 ADD: each cycle SHALL add nibble k of a and b with the registered carry, write the 4-bit sum into res_sum[4k+3:4k], register the carry-out, and increment k.
REQ-023 After nibble NIBBLES-1 the FSM SHALL go to HOLD with res_valid=1 and res_carry = final carry.
REQ-024 Latency: res_valid SHALL rise exactly NIBBLES cycles after the acceptance edge.
REQ-025 HOLD: res_valid, res_sum, res_carry, res_id SHALL remain stable until res_ready=1; on that edge go to IDLE and drop res_valid.
REQ-026 Both req_ready SHALL be 0 in ADD and HOLD; the block SHALL hold at most one operation.
REQ-027 Input operand changes after acceptance SHALL not affect the result.
REQ-028 A requester dropping valid before grant SHALL not be granted and SHALL not alter round-robin state.
REQ-029 Arithmetic SHALL be modulo 2^W with carry-out in res_carry; e.g. all-ones + 0 + ci=1 -> sum 0, carry 1.
REQ-030 res_sum SHALL hold the previous result's bits until overwritten nibble-by-nibble; only values while res_valid=1 are defined.

Reset
REQ-031 reset=1 at a rising edge SHALL force state IDLE, res_valid=0, res_sum=0, res_carry=0, res_id=0, counter=0, carry register 0, last-grant = requester 1 (so requester 0 wins next tie).
REQ-032 Reset during ADD or HOLD SHALL discard the operation; its result SHALL never appear.
REQ-033 req0_ready and req1_ready SHALL be 0 in any cycle where reset=1.

Verification (NIBBLES=4 unless noted)
REQ-034 req0 a=0x1234 b=0x4321 ci=0, res_ready=1 -> res_valid 4 cycles after accept, sum=0x5555, carry=0, id=0.
REQ-035 req1 a=0xFFFF b=0x0000 ci=1 -> sum=0x0000, carry=1, id=1 (carry ripples through all 4 nibbles).
REQ-036 After reset both valid continuously (req0 0x0001+0x0001, req1 0x00FF+0x0001) -> req0 granted first (0x0002, id 0), then req1 (0x0100, id 1), alternating thereafter.
REQ-037 res_ready=0 for 10 cycles in HOLD -> res_valid/res_sum/res_carry/res_id constant, both req_ready=0; release -> single transfer, IDLE next cycle.
REQ-038 reset pulsed during ADD (k=2) -> next cycle all outputs 0, IDLE; no res_valid for the aborted op; next request processed normally.
REQ-039 NIBBLES=1: a=0x9 b=0x8 ci=1 -> res_valid 1 cycle after accept, sum=0x2, carry=1.

Source files
------------

// File: rtl/add_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : add_scheduler
// Brief    : Two-requester round-robin front end that time-shares one 4-bit
//            ripple adder to add W-bit operands one nibble per cycle.
// Revision : 1.0
// ============================================================================

module adder4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);
    logic [4:0] w_c;

    assign w_c[0] = ci_i;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
        assign w_c[i+1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
    end

    assign co_o = w_c[4];
endmodule

module add_scheduler #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [W-1:0] req0_a_i,
    input  logic [W-1:0] req0_b_i,
    input  logic         req0_ci_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [W-1:0] req1_a_i,
    input  logic [W-1:0] req1_b_i,
    input  logic         req1_ci_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [W-1:0] res_sum_o,
    output logic         res_carry_o,
    output logic         res_id_o
);
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [KW-1:0] k_q, k_d;
    logic          carry_q, carry_d, id_q, id_d, last_q, last_d;

    logic          w_grant;
    logic [3:0]    w_nib_a, w_nib_b, w_nib_s;
    logic          w_nib_co;

    adder4 u_adder (
        .a_i  (w_nib_a),
        .b_i  (w_nib_b),
        .ci_i (carry_q),
        .s_o  (w_nib_s),
        .co_o (w_nib_co)
    );

    // On a tie the requester not served last wins; a lone requester always wins.
    assign w_grant = (req0_valid_i && req1_valid_i) ? ~last_q : req1_valid_i;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        k_d          = k_q;
        carry_d      = carry_q;
        id_d         = id_q;
        last_d       = last_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        w_nib_a      = 4'd0;
        w_nib_b      = 4'd0;

        for (int n = 0; n < NIBBLES; n++) begin
            if (k_q == KW'(n)) begin
                w_nib_a = a_q[4*n +: 4];
                w_nib_b = b_q[4*n +: 4];
            end
        end

        case (state_q)
            IDLE: begin
                if (!reset) begin
                    req0_ready_o = req0_valid_i && !w_grant;
                    req1_ready_o = req1_valid_i &&  w_grant;
                end
                if (req0_ready_o || req1_ready_o) begin
                    a_d     = w_grant ? req1_a_i  : req0_a_i;
                    b_d     = w_grant ? req1_b_i  : req0_b_i;
                    carry_d = w_grant ? req1_ci_i : req0_ci_i;
                    id_d    = w_grant;
                    last_d  = w_grant;
                    k_d     = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (k_q == KW'(n)) sum_d[4*n +: 4] = w_nib_s;
                end
                carry_d = w_nib_co;
                if (k_q == KW'(NIBBLES - 1)) state_d = HOLD;
                else                         k_d     = k_q + KW'(1);
            end
            HOLD: begin
                if (res_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign res_valid_o = (state_q == HOLD);
    assign res_sum_o   = sum_q;
    assign res_carry_o = carry_q;
    assign res_id_o    = id_q;
endmodule

`default_nettype wire

// File: tb/tb_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_scheduler
// Brief    : Directed bench for add_scheduler (NIBBLES=4 and NIBBLES=1).
// Revision : 1.0
// ============================================================================

module tb_add_scheduler;
    logic        clk = 1'b0;
    logic        reset;

    logic        v0, r0, ci0, v1, r1, ci1, rv, rr, rc, rid;
    logic [15:0] a0, b0, a1, b1, rs;

    logic        n_v0, n_r0, n_ci0, n_v1, n_r1, n_ci1, n_rv, n_rr, n_rc, n_rid;
    logic [3:0]  n_a0, n_b0, n_a1, n_b1, n_rs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    add_scheduler #(.NIBBLES(4)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(v0), .req0_ready_o(r0), .req0_a_i(a0), .req0_b_i(b0), .req0_ci_i(ci0),
        .req1_valid_i(v1), .req1_ready_o(r1), .req1_a_i(a1), .req1_b_i(b1), .req1_ci_i(ci1),
        .res_valid_o(rv), .res_ready_i(rr), .res_sum_o(rs), .res_carry_o(rc), .res_id_o(rid)
    );

    add_scheduler #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req0_valid_i(n_v0), .req0_ready_o(n_r0), .req0_a_i(n_a0), .req0_b_i(n_b0), .req0_ci_i(n_ci0),
        .req1_valid_i(n_v1), .req1_ready_o(n_r1), .req1_a_i(n_a1), .req1_b_i(n_b1), .req1_ci_i(n_ci1),
        .res_valid_o(n_rv), .res_ready_i(n_rr), .res_sum_o(n_rs), .res_carry_o(n_rc), .res_id_o(n_rid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the acceptance edge: result must appear on edge n exactly.
    task automatic wait_result(input int n, input string tag);
        for (int i = 1; i < n; i++) begin
            tick();
            check({tag, "_early"}, rv, 0);
        end
        tick();
        check({tag, "_valid"}, rv, 1);
    endtask

    initial begin
        reset = 1'b1;
        v0 = 1'b1; a0 = 16'h0; b0 = 16'h0; ci0 = 1'b0;
        v1 = 1'b1; a1 = 16'h0; b1 = 16'h0; ci1 = 1'b0;
        rr = 1'b1;
        n_v0 = 1'b0; n_a0 = 4'h0; n_b0 = 4'h0; n_ci0 = 1'b0;
        n_v1 = 1'b0; n_a1 = 4'h0; n_b1 = 4'h0; n_ci1 = 1'b0;
        n_rr = 1'b1;

        // Reset state; ready suppressed while reset is high
        tick();
        tick();
        check("rst_valid", rv, 0);
        check("rst_sum",   rs, 0);
        check("rst_carry", rc, 0);
        check("rst_id",    rid, 0);
        check("rst_rdy0",  r0, 0);
        check("rst_rdy1",  r1, 0);
        reset = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        #1;
        check("idle_rdy0_novalid", r0, 0);

        // Basic add from requester 0; operand change after accept is ignored
        v0 = 1'b1; a0 = 16'h1234; b0 = 16'h4321; ci0 = 1'b0;
        #1;
        check("basic_rdy0", r0, 1);
        check("basic_rdy1", r1, 0);
        tick();
        v0 = 1'b0; a0 = 16'hAAAA; b0 = 16'hBBBB;
        check("basic_busy_rdy0", r0, 0);
        wait_result(4, "basic");
        check("basic_sum",   rs, 16'h5555);
        check("basic_carry", rc, 0);
        check("basic_id",    rid, 0);
        tick();
        check("basic_drop", rv, 0);

        // Full carry ripple from requester 1, then a 10-cycle stall in HOLD
        rr = 1'b0;
        v1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0000; ci1 = 1'b1;
        #1;
        check("ripple_rdy1", r1, 1);
        check("ripple_rdy0", r0, 0);
        tick();
        v1 = 1'b0;
        wait_result(4, "ripple");
        check("ripple_sum",   rs, 16'h0000);
        check("ripple_carry", rc, 1);
        check("ripple_id",    rid, 1);
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", rv, 1);
            check("hold_sum",   rs, 16'h0000);
            check("hold_carry", rc, 1);
            check("hold_id",    rid, 1);
            check("hold_rdy0",  r0, 0);
            check("hold_rdy1",  r1, 0);
        end
        v0 = 1'b0; v1 = 1'b0;
        rr = 1'b1;
        tick();
        check("release_drop", rv, 0);
        v0 = 1'b1;
        #1;
        check("release_idle_rdy0", r0, 1);
        v0 = 1'b0;

        // Round-robin after a fresh reset with both requesters always valid
        reset = 1'b1;
        tick();
        reset = 1'b0;
        v0 = 1'b1; a0 = 16'h0001; b0 = 16'h0001; ci0 = 1'b0;
        v1 = 1'b1; a1 = 16'h00FF; b1 = 16'h0001; ci1 = 1'b0;
        #1;
        check("rr1_rdy0", r0, 1);
        check("rr1_rdy1", r1, 0);
        tick();
        wait_result(4, "rr1");
        check("rr1_sum", rs, 16'h0002);
        check("rr1_id",  rid, 0);
        tick();
        check("rr2_rdy1", r1, 1);
        check("rr2_rdy0", r0, 0);
        tick();
        wait_result(4, "rr2");
        check("rr2_sum", rs, 16'h0100);
        check("rr2_id",  rid, 1);
        tick();
        check("rr3_rdy0", r0, 1);
        check("rr3_rdy1", r1, 0);
        tick();
        wait_result(4, "rr3");
        check("rr3_sum", rs, 16'h0002);
        check("rr3_id",  rid, 0);
        tick();
        v0 = 1'b0; v1 = 1'b0;

        // A valid pulse that never meets an edge must not disturb arbitration
        v0 = 1'b1;
        #1;
        v0 = 1'b0;
        #1;
        check("pulse_rdy0", r0, 0);
        check("pulse_rdy1", r1, 0);
        v0 = 1'b1; v1 = 1'b1;
        #1;
        check("pulse_rdy1_tie", r1, 1);
        check("pulse_rdy0_tie", r0, 0);
        v0 = 1'b0;
        tick();
        v1 = 1'b0;
        wait_result(4, "pulse");
        check("pulse_sum", rs, 16'h0100);
        check("pulse_id",  rid, 1);
        tick();

        // Reset while the third nibble is being added
        v0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; ci0 = 1'b1;
        tick();
        v0 = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        v0 = 1'b1;
        #1;
        check("abort_rst_rdy0", r0, 0);
        tick();
        reset = 1'b0;
        v0 = 1'b0;
        check("abort_valid", rv, 0);
        check("abort_sum",   rs, 0);
        check("abort_carry", rc, 0);
        check("abort_id",    rid, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_result", rv, 0);
        end
        v1 = 1'b1; a1 = 16'h0010; b1 = 16'h0020; ci1 = 1'b0;
        #1;
        check("post_abort_rdy1", r1, 1);
        tick();
        v1 = 1'b0;
        wait_result(4, "post_abort");
        check("post_abort_sum",   rs, 16'h0030);
        check("post_abort_carry", rc, 0);
        check("post_abort_id",    rid, 1);
        tick();

        // Single-nibble instance: 9 + 8 + 1 = 0x12
        n_v0 = 1'b1; n_a0 = 4'h9; n_b0 = 4'h8; n_ci0 = 1'b1;
        #1;
        check("n1_rdy0", n_r0, 1);
        tick();
        n_v0 = 1'b0;
        tick();
        check("n1_valid", n_rv, 1);
        check("n1_sum",   n_rs, 4'h2);
        check("n1_carry", n_rc, 1);
        check("n1_id",    n_rid, 0);
        tick();
        check("n1_drop", n_rv, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
